// File: rtl/lnrv_exu_wbck_arb_pkg.sv
// ----------------------------------------------------------------------------
// lnrv_exu_wbck_arb_pkg
// Shared constants for the execute-stage writeback arbiter:
//   - default widths (request count, data width, destination index width)
//   - source unit index constants (bit position in req_* / wbck_src)
//   - WBCK_RR_EN, mirroring the LNRV_WBCK_RR_EN build macro
//     (defined: round-robin arbitration, undefined: fixed priority, index 0 wins)
// ----------------------------------------------------------------------------
package lnrv_exu_wbck_arb_pkg;

    localparam int WBCK_NUM_REQ = 4;
    localparam int WBCK_XLEN    = 32;
    localparam int WBCK_RD_W    = 5;

    localparam int WBCK_SRC_RGLR = 0;
    localparam int WBCK_SRC_LSU  = 1;
    localparam int WBCK_SRC_CSR  = 2;
    localparam int WBCK_SRC_MDV  = 3;

`ifdef LNRV_WBCK_RR_EN
    localparam bit WBCK_RR_EN = 1'b1;
`else
    localparam bit WBCK_RR_EN = 1'b0;
`endif

endpackage

// File: rtl/lnrv_exu_wbck_arb_if.sv
// ----------------------------------------------------------------------------
// lnrv_exu_wbck_arb_if
// Bundles the per-unit writeback request buses and the regfile write port.
//   req_vld      unit -> arb   per-unit request valid
//   req_rdy      arb  -> unit  per-unit accept
//   req_rd_idx   unit -> arb   unit i at [i*RD_W +: RD_W]
//   req_rd_data  unit -> arb   unit i at [i*XLEN +: XLEN]
//   wbck_vld     arb  -> rf    registered write request
//   wbck_rdy     rf   -> arb   regfile accepts the write
//   wbck_rd_idx  arb  -> rf    registered destination index
//   wbck_rd_data arb  -> rf    registered write data
//   wbck_src     arb  -> rf    one-hot source of the held entry
//   wbck_idle    arb  -> any   nothing held and nothing requested
// Modports: slave = arbiter side, master = units/regfile side.
// ----------------------------------------------------------------------------
interface lnrv_exu_wbck_arb_if
    import lnrv_exu_wbck_arb_pkg::*;
#(
    parameter int NUM_REQ = WBCK_NUM_REQ,
    parameter int XLEN    = WBCK_XLEN,
    parameter int RD_W    = WBCK_RD_W
);

    logic [NUM_REQ-1:0]      req_vld;
    logic [NUM_REQ-1:0]      req_rdy;
    logic [NUM_REQ*RD_W-1:0] req_rd_idx;
    logic [NUM_REQ*XLEN-1:0] req_rd_data;

    logic                    wbck_vld;
    logic                    wbck_rdy;
    logic [RD_W-1:0]         wbck_rd_idx;
    logic [XLEN-1:0]         wbck_rd_data;
    logic [NUM_REQ-1:0]      wbck_src;
    logic                    wbck_idle;

    modport slave (
        input  req_vld, req_rd_idx, req_rd_data, wbck_rdy,
        output req_rdy, wbck_vld, wbck_rd_idx, wbck_rd_data, wbck_src, wbck_idle
    );

    modport master (
        output req_vld, req_rd_idx, req_rd_data, wbck_rdy,
        input  req_rdy, wbck_vld, wbck_rd_idx, wbck_rd_data, wbck_src, wbck_idle
    );

endinterface

// File: rtl/lnrv_rr_arb.sv
// ----------------------------------------------------------------------------
// lnrv_rr_arb
// Combinational one-hot arbiter.
//   req    in   N  request vector
//   ptr    in   N  one-hot highest-priority index (used only when en = 1)
//   en     in   1  1: round-robin starting at ptr, 0: fixed priority, bit 0 wins
//   grant  out  N  one-hot grant, zero when req is zero
// ----------------------------------------------------------------------------
module lnrv_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] pick;

    always_comb begin
        // bits at or above the pointer position; requests there go first,
        // otherwise wrap around to the lowest asserted request
        hi_mask = ~(ptr - ONE);
        hi_req  = en ? (req & hi_mask) : req;
        pick    = (hi_req != '0) ? hi_req : req;
        // isolate the lowest set bit
        grant   = pick & (~pick + ONE);
    end

endmodule

// File: rtl/lnrv_exu_wbck_arb.sv
// ----------------------------------------------------------------------------
// lnrv_exu_wbck_arb
// Shares the integer regfile write port among the result-producing units
// (0 rglr, 1 lsu, 2 csr, 3 mdv). One request is granted per cycle and the
// winner is registered into a one-entry output stage driving the regfile.
// Writes to x0 complete the handshake but are never forwarded.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of lnrv_exu_wbck_arb_if (request + write port)
//
// Build option: LNRV_WBCK_RR_EN selects round-robin arbitration with a
// one-hot pointer register; without it, fixed priority (lowest index wins)
// and no pointer register is built.
// NUM_REQ/XLEN/RD_W must match the parameters of the connected interface.
// ----------------------------------------------------------------------------
module lnrv_exu_wbck_arb
    import lnrv_exu_wbck_arb_pkg::*;
#(
    parameter int NUM_REQ = WBCK_NUM_REQ,
    parameter int XLEN    = WBCK_XLEN,
    parameter int RD_W    = WBCK_RD_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lnrv_exu_wbck_arb_if.slave   bus
);

    // pointer reset value: index 0 holds highest priority
    localparam logic [NUM_REQ-1:0] PTR_RST = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic                stage_free;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  req_rdy_c;
    logic                accept;
    logic [RD_W-1:0]     sel_idx;
    logic [XLEN-1:0]     sel_data;
    logic                sel_wr;
    logic [NUM_REQ-1:0]  rr_ptr;

    logic                wbck_vld_q;
    logic [RD_W-1:0]     wbck_idx_q;
    logic [XLEN-1:0]     wbck_data_q;
    logic [NUM_REQ-1:0]  wbck_src_q;

    assign stage_free = ~wbck_vld_q | bus.wbck_rdy;

    lnrv_rr_arb #(
        .N     (NUM_REQ)
    ) u_arb (
        .req   (bus.req_vld),
        .ptr   (rr_ptr),
        .en    (WBCK_RR_EN),
        .grant (grant)
    );

    assign req_rdy_c = grant & {NUM_REQ{stage_free}};
    assign accept    = |req_rdy_c;

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = sel_idx  | bus.req_rd_idx[i*RD_W +: RD_W];
                sel_data = sel_data | bus.req_rd_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 destinations are consumed here and never reach the regfile
    assign sel_wr = (sel_idx != '0);

`ifdef LNRV_WBCK_RR_EN
    // after granting index k, index k+1 (mod NUM_REQ) gets top priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= PTR_RST;
        end else if (accept) begin
            rr_ptr <= (grant << 1) | (grant >> (NUM_REQ - 1));
        end
    end
`else
    assign rr_ptr = PTR_RST;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbck_vld_q  <= 1'b0;
            wbck_idx_q  <= '0;
            wbck_data_q <= '0;
            wbck_src_q  <= '0;
        end else if (accept && sel_wr) begin
            // also covers retire-and-replace on the same edge
            wbck_vld_q  <= 1'b1;
            wbck_idx_q  <= sel_idx;
            wbck_data_q <= sel_data;
            wbck_src_q  <= grant;
        end else if (wbck_vld_q && bus.wbck_rdy) begin
            wbck_vld_q  <= 1'b0;
        end
    end

    assign bus.req_rdy      = req_rdy_c;
    assign bus.wbck_vld     = wbck_vld_q;
    assign bus.wbck_rd_idx  = wbck_idx_q;
    assign bus.wbck_rd_data = wbck_data_q;
    assign bus.wbck_src     = wbck_src_q;
    assign bus.wbck_idle    = ~wbck_vld_q & ~(|bus.req_vld);

endmodule

// File: tb/tb_lnrv_exu_wbck_arb.sv
module tb_lnrv_exu_wbck_arb;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int RW = 5;

    logic clk;
    logic reset_n;

    lnrv_exu_wbck_arb_if #(.NUM_REQ(N), .XLEN(XL), .RD_W(RW)) bus ();

    lnrv_exu_wbck_arb #(.NUM_REQ(N), .XLEN(XL), .RD_W(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ptr;
    logic        m_vld;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic [3:0]  m_src;

    function automatic int model_pick(input logic [3:0] req);
        for (int k = 0; k < N; k++) begin
            int j;
`ifdef LNRV_WBCK_RR_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 1'b0; m_idx = '0; m_data = '0; m_src = '0;
    endtask

    task automatic model_check(input string tag);
        int g;
        logic free;
        logic [3:0] exp_rdy;
        g = model_pick(bus.req_vld);
        free = !m_vld || bus.wbck_rdy;
        exp_rdy = '0;
        if (free && g >= 0) exp_rdy[g] = 1'b1;
        check({tag, "_req_rdy"}, bus.req_rdy, exp_rdy);
        check({tag, "_vld"}, bus.wbck_vld, m_vld);
        check({tag, "_idle"}, bus.wbck_idle, !m_vld && bus.req_vld == 4'b0);
        if (m_vld) begin
            check({tag, "_idx"}, bus.wbck_rd_idx, m_idx);
            check({tag, "_data"}, bus.wbck_rd_data, m_data);
            check({tag, "_src"}, bus.wbck_src, m_src);
        end
    endtask

    // advance the model across a rising edge using the inputs held over it
    task automatic model_step();
        int g;
        logic free;
        logic [4:0] idx;
        g = model_pick(bus.req_vld);
        free = !m_vld || bus.wbck_rdy;
        if (free && g >= 0) begin
            m_ptr = (g + 1) % N;
            idx = bus.req_rd_idx[g*RW +: RW];
            if (idx != 0) begin
                m_vld  = 1'b1;
                m_idx  = idx;
                m_data = bus.req_rd_data[g*XL +: XL];
                m_src  = '0;
                m_src[g] = 1'b1;
            end else if (m_vld && bus.wbck_rdy) begin
                m_vld = 1'b0;
            end
        end else if (m_vld && bus.wbck_rdy) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic model_cycle(input string tag);
        @(negedge clk);
        model_check(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]   req;
        logic         rdy;
        logic [19:0]  idx;
        logic [127:0] data;
        logic [3:0]   e_rdy;
        logic         e_vld;
        logic [4:0]   e_idx;
        logic [31:0]  e_data;
        logic [3:0]   e_src;
        logic         e_idle;
    } vec_t;

    vec_t tbl[11];
    int   exp_ord[5];

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.req_vld = '0; bus.req_rd_idx = '0; bus.req_rd_data = '0; bus.wbck_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] oh;
        tbl[0]  = '{4'b0000, 1'b1, 20'h00000, 128'h0,         4'b0000, 1'b0, 5'd0, 32'h0,    4'b0000, 1'b1};
        tbl[1]  = '{4'b0001, 1'b1, 20'h00005, 128'h1234,      4'b0001, 1'b0, 5'd0, 32'h0,    4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 20'h00005, 128'h1234,      4'b0000, 1'b1, 5'd5, 32'h1234, 4'b0001, 1'b0};
        tbl[3]  = '{4'b0010, 1'b0, 20'h000E0, 128'hBEEF << 32, 4'b0000, 1'b1, 5'd5, 32'h1234, 4'b0001, 1'b0};
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = '{4'b0010, 1'b1, 20'h000E0, 128'hBEEF << 32, 4'b0010, 1'b1, 5'd5, 32'h1234, 4'b0001, 1'b0};
        tbl[7]  = '{4'b0000, 1'b1, 20'h00000, 128'h0,         4'b0000, 1'b1, 5'd7, 32'hBEEF, 4'b0010, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 20'h00000, 128'h0,         4'b0000, 1'b0, 5'd0, 32'h0,    4'b0000, 1'b1};
        tbl[9]  = '{4'b0100, 1'b1, 20'h00000, 128'hDEAD << 64, 4'b0100, 1'b0, 5'd0, 32'h0,    4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 20'h00000, 128'h0,         4'b0000, 1'b0, 5'd0, 32'h0,    4'b0000, 1'b1};
`ifdef LNRV_WBCK_RR_EN
        // pointer sits at 3 after the table (grants 0, 1, then x0 write at 2)
        exp_ord = '{3, 0, 1, 2, 3};
`else
        exp_ord = '{0, 0, 0, 0, 0};
`endif

        // reset values
        reset_n = 1'b0;
        bus.req_vld = '0; bus.req_rd_idx = '0; bus.req_rd_data = '0; bus.wbck_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", bus.wbck_vld, 1'b0);
        check("rst_idx", bus.wbck_rd_idx, 5'd0);
        check("rst_data", bus.wbck_rd_data, 32'd0);
        check("rst_src", bus.wbck_src, 4'd0);
        check("rst_idle", bus.wbck_idle, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            bus.req_vld     = tbl[i].req;
            bus.wbck_rdy    = tbl[i].rdy;
            bus.req_rd_idx  = tbl[i].idx;
            bus.req_rd_data = tbl[i].data;
            @(negedge clk);
            check($sformatf("v%0d_req_rdy", i), bus.req_rdy, tbl[i].e_rdy);
            check($sformatf("v%0d_vld", i), bus.wbck_vld, tbl[i].e_vld);
            check($sformatf("v%0d_idle", i), bus.wbck_idle, tbl[i].e_idle);
            if (tbl[i].e_vld) begin
                check($sformatf("v%0d_idx", i), bus.wbck_rd_idx, tbl[i].e_idx);
                check($sformatf("v%0d_data", i), bus.wbck_rd_data, tbl[i].e_data);
                check($sformatf("v%0d_src", i), bus.wbck_src, tbl[i].e_src);
            end
            @(posedge clk);
            #1;
        end

        // contention with all four units requesting
        for (int c = 0; c < 5; c++) begin
            bus.req_vld     = 4'b1111;
            bus.wbck_rdy    = 1'b1;
            bus.req_rd_idx  = {5'd4, 5'd3, 5'd2, 5'd1};
            bus.req_rd_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
            @(negedge clk);
            oh = '0; oh[exp_ord[c]] = 1'b1;
            check($sformatf("cont%0d_grant", c), bus.req_rdy, oh);
            if (c > 0) begin
                oh = '0; oh[exp_ord[c-1]] = 1'b1;
                check($sformatf("cont%0d_src", c), bus.wbck_src, oh);
                check($sformatf("cont%0d_vld", c), bus.wbck_vld, 1'b1);
            end
            @(posedge clk);
            #1;
        end
        bus.req_vld  = '0;
        bus.wbck_rdy = 1'b0;
        @(negedge clk);
        oh = '0; oh[exp_ord[4]] = 1'b1;
        check("cont_last_vld", bus.wbck_vld, 1'b1);
        check("cont_last_src", bus.wbck_src, oh);
        check("cont_last_idx", bus.wbck_rd_idx, 5'(exp_ord[4] + 1));

        // asynchronous reset while an entry is held
        #2 reset_n = 1'b0;
        #1;
        check("arst_vld", bus.wbck_vld, 1'b0);
        check("arst_src", bus.wbck_src, 4'd0);
        check("arst_data", bus.wbck_rd_data, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.req_vld     = 4'b1010;
        bus.wbck_rdy    = 1'b1;
        bus.req_rd_idx  = {5'd9, 5'd0, 5'd3, 5'd0};
        bus.req_rd_data = {32'h33, 32'h0, 32'h11, 32'h0};
        @(negedge clk);
        check("post_rst_grant", bus.req_rdy, 4'b0010);
        @(posedge clk);
        #1;
        bus.req_vld = '0;
        @(negedge clk);
        check("post_rst_vld", bus.wbck_vld, 1'b1);
        check("post_rst_idx", bus.wbck_rd_idx, 5'd3);
        check("post_rst_data", bus.wbck_rd_data, 32'h11);
        check("post_rst_src", bus.wbck_src, 4'b0010);

        // randomized traffic against the reference model
        apply_reset();
        model_reset();
        for (int r = 0; r < 400; r++) begin
            bus.req_vld = 4'($urandom_range(0, 15));
            for (int u = 0; u < N; u++) begin
                bus.req_rd_idx[u*RW +: RW]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.req_rd_data[u*XL +: XL] = $urandom;
            end
            bus.wbck_rdy = ($urandom_range(0, 3) != 0);
            model_cycle($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lnrv_exu_wbck_arb.md
# lnrv_exu_wbck_arb

Writeback arbiter for the execute stage: it shares the single integer register-file write port among the execution units that produce results (regular ALU, LSU, CSR, mul/div). Each unit presents a valid/ready writeback request; the block grants one per cycle and registers the winner into a one-entry output stage that drives the register file. It sits between the unit result buses and the regfile write port, downstream of the dispatch logic.

## Interface
- NUM_REQ, 4, number of requesting units; index 0 = rglr, 1 = lsu, 2 = csr, 3 = mdv.
- XLEN, 32, data width.
- RD_W, 5, destination register index width.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_vld  in  NUM_REQ  per-unit writeback request valid.
- req_rdy  out  NUM_REQ  per-unit grant/accept; a request transfers when req_vld[i] & req_rdy[i].
- req_rd_idx  in  NUM_REQ*RD_W  per-unit destination index, unit i at [i*RD_W +: RD_W].
- req_rd_data  in  NUM_REQ*XLEN  per-unit result, unit i at [i*XLEN +: XLEN].
- wbck_vld  out  1  registered write request to the regfile.
- wbck_rdy  in  1  regfile accepts the write.
- wbck_rd_idx  out  RD_W  registered destination index.
- wbck_rd_data  out  XLEN  registered write data.
- wbck_src  out  NUM_REQ  one-hot source of the current output entry (for tracing and scoreboard release).
- wbck_idle  out  1  no output entry held and no request pending.

## Operation
- Output stage holds at most one entry; stage_free = ~wbck_vld | (wbck_vld & wbck_rdy).
- Grant: combinational one-hot selection among the asserted req_vld bits. With NUM_REQ == 0 requests asserted, grant = 0.
- req_rdy[i] = grant[i] & stage_free; at most one req_rdy bit is high in any cycle; req_rdy never asserts for an unasserted req_vld.
- Accepted request: wbck_rd_idx, wbck_rd_data and wbck_src load from the granted unit; wbck_vld is set next cycle.
- rd_idx == 0: the request is accepted (handshake completes, req_rdy high) but wbck_vld is not set and the output registers are not loaded. The cycle still counts as a grant for pointer update.
- Output entry retire: wbck_vld & wbck_rdy with no new accept clears wbck_vld. Idx, data and src hold their values, so they are don't-care once wbck_vld is low.
- Simultaneous retire and accept: the new entry replaces the old one in the same edge; wbck_vld stays 1.
- While wbck_vld & ~wbck_rdy, all req_rdy are 0 and the output registers are stable (valid/data held until accepted).
- Requesters must hold req_vld, idx and data stable until accepted. The arbiter does not depend on this for correctness of its own state.
- wbck_idle = ~wbck_vld & ~|req_vld.

## Timing
- Reset values: wbck_vld = 0, wbck_rd_idx = 0, wbck_rd_data = 0, wbck_src = 0, rr pointer = 0; req_rdy follows combinationally (all 1-capable since the stage is free).
- Latency: request accepted in cycle N appears on wbck_* in cycle N+1.
- Throughput: one writeback per cycle when wbck_rdy is held high.
- No combinational path from wbck_rdy to wbck_vld. A combinational path from wbck_rdy to req_rdy exists through stage_free, and is allowed.
- If reset asserts mid-transfer, the held entry is dropped and the pointer returns to 0.

## Configuration
- LNRV_WBCK_RR_EN defined: round-robin arbitration. A NUM_REQ-bit pointer marks the highest-priority index. On each accepted grant to index k, the pointer moves to (k+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0. The pointer does not move without an accept.
- LNRV_WBCK_RR_EN undefined: fixed priority, with the lowest index winning. No pointer register exists.

## Structure
- Shared package or defines file: RD_W and XLEN defaults, the unit index constants (WBCK_SRC_RGLR = 0, WBCK_SRC_LSU = 1, WBCK_SRC_CSR = 2, WBCK_SRC_MDV = 3), and the LNRV_WBCK_RR_EN switch.
- One sub-module: lnrv_rr_arb, a parameterised one-hot arbiter taking req, pointer and an enable, and producing grant. The top level holds the pointer and the output stage.

## Test plan
- Single request: after reset, req_vld = 4'b0001, idx 5, data 0x1234 with wbck_rdy = 1 -> req_rdy[0] = 1 in cycle N; wbck_vld = 1, idx 5, data 0x1234, src 4'b0001 in N+1.
- Back-pressure: wbck_rdy = 0 while an entry is held and req_vld = 4'b0010 -> req_rdy = 0 and the output is stable for 3 cycles. With wbck_rdy = 1, the held entry retires and the LSU entry loads on the same edge.
- Contention, RR enabled: req_vld = 4'b1111 held with wbck_rdy = 1 -> grant order 0, 1, 2, 3, 0 over 5 cycles (pointer wraps 3 -> 0).
- Contention, RR disabled: same stimulus -> unit 0 is granted every cycle and units 1-3 are starved.
- x0 write: req_vld[2] with idx 0 -> req_rdy[2] = 1 and wbck_vld stays 0. With RR enabled, the next grant from 4'b1111 goes to index 3.
- Reset mid-operation: reset_n is pulled low while wbck_vld = 1 -> wbck_vld = 0 immediately, and after release the first grant from 4'b1010 goes to index 1.
